four_phase_rx: RTL

//  Destination-side responder of the four-phase (return-to-zero) req/ack bundled-data handshake.

---
 rtl/fph_pkg.sv | 17 +
 rtl/four_phase_rx_sync.sv | 34 +++
 rtl/four_phase_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/fph_pkg.sv
// Shared types and constants for the four-phase bundled-data receiver.
package fph_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACKH = 1'b1
    } rx_state_t;

    localparam int FPH_MIN_SYNC = 2;
    localparam int FPH_CNT_W    = 16;

    // The output buffer can take a new word if it is empty or is being drained on this edge.
    function automatic logic buf_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/four_phase_rx_sync.sv
// Single-bit flop-chain synchroniser; every stage resets asynchronously to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic w_stage_in;
            if (gi == 0) begin : g_first
                assign w_stage_in = i_d;
            end else begin : g_rest
                assign w_stage_in = r_sync[gi-1];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= w_stage_in;
                end
            end
        end
    endgenerate

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/four_phase_rx.sv
// Receive half of a four-phase req/ack bundled-data link: synchronises req, captures the
// bundled word into a one-entry buffer, returns ack and offers the word as a valid/ready stream.
module four_phase_rx
    import fph_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 reqAsync,
    input  logic [N-1:0]         dataAsync,
    output logic                 ack,
    output logic                 validOut,
    output logic [N-1:0]         dataOut,
    input  logic                 readyIn,
    output logic [FPH_CNT_W-1:0] xferCount
);

    generate
        if (SYNC_STAGES < FPH_MIN_SYNC) begin : g_sync_check
            $error("four_phase_rx: SYNC_STAGES must be at least FPH_MIN_SYNC");
        end
    endgenerate

    logic                 w_req_s;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic                 r_ack;
    logic                 w_ack_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic [N-1:0]         r_data;
    logic [N-1:0]         w_data_next;
    logic [FPH_CNT_W-1:0] r_count;
    logic [FPH_CNT_W-1:0] w_count_next;
    logic                 w_buf_free;
    logic                 w_capture;
    logic                 w_accept;

    // dataAsync is deliberately not synchronised: it is stable while reqS is high.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (reqAsync),
        .o_q     (w_req_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        w_capture    = 1'b0;
        w_accept     = r_valid && readyIn;
        w_buf_free   = buf_free(r_valid, readyIn);

        case (r_state)
            IDLE: begin
                // Holding ack low while the buffer is full is the backpressure path to the sender.
                if (w_req_s && w_buf_free) begin
                    w_capture    = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = ACKH;
                end
            end
            ACKH: begin
                if (!w_req_s) begin
                    w_ack_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
        endcase

        w_data_next  = w_capture ? dataAsync : r_data;
        w_valid_next = w_capture ? 1'b1 : (w_accept ? 1'b0 : r_valid);
        w_count_next = w_accept ? r_count + 1'b1 : r_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_valid <= w_valid_next;
            r_data  <= w_data_next;
            r_count <= w_count_next;
        end
    end

    assign ack       = r_ack;
    assign validOut  = r_valid;
    assign dataOut   = r_data;
    assign xferCount = r_count;

endmodule
